// File: rtl/pp_hop_extract.sv
// Purpose : Path Parser front end; turns each packet's hop words into hop_info records
//           {type, rci, byte_pointer} and writes them into one of two ping-pong hop FIFOs.
// Latency : one cycle from hop word acceptance to FIFO write; FIFO clear and meta post are
//           issued together, one cycle before the first hop word can be accepted.
// Backpressure: hop_in_ready drops when the active FIFO is full, or one entry from full
//           with a write already in flight; a packet waits until its FIFO has been released.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   hop_in_*                      hop word stream (valid/ready, sop/eop, cur_idx/pkt_rci on sop)
//   hop_fifo_reset0/1             one-cycle clear of FIFO 0/1 before a packet is written
//   hop_fifo_wr0/1, _wdata0/1     FIFO write strobe and {type, rci, byte_pointer}
//   hop_fifo_full0/1, _fullm10/1  FIFO full / one-from-full status
//   parse_done0/1                 parser has finished with FIFO 0/1 (releases it)
//   pp_meta_valid, pp_meta_rci    packet RCI posted to the parser meta FIFO
//   trunc_err                     one-cycle pulse when a packet has more than 2^IDX_NBITS hops
module pp_hop_extract #(
    parameter int                  RCI_NBITS       = 16,
    parameter int                  BP_NBITS        = 12,
    parameter int                  HDR_OFFSET      = 24,
    parameter logic [BP_NBITS-1:0] INITIAL_HOP_PTR = 12'hFFF,
    parameter int                  IDX_NBITS       = 6
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              hop_in_valid,
    output logic                              hop_in_ready,
    input  logic                              hop_in_sop,
    input  logic                              hop_in_eop,
    input  logic [31:0]                       hop_in_data,
    input  logic [IDX_NBITS-1:0]              hop_in_cur_idx,
    input  logic [RCI_NBITS-1:0]              hop_in_pkt_rci,

    output logic                              hop_fifo_reset0,
    output logic                              hop_fifo_reset1,
    output logic                              hop_fifo_wr0,
    output logic                              hop_fifo_wr1,
    output logic [3+RCI_NBITS+BP_NBITS-1:0]   hop_fifo_wdata0,
    output logic [3+RCI_NBITS+BP_NBITS-1:0]   hop_fifo_wdata1,
    input  logic                              hop_fifo_full0,
    input  logic                              hop_fifo_full1,
    input  logic                              hop_fifo_fullm10,
    input  logic                              hop_fifo_fullm11,
    input  logic                              parse_done0,
    input  logic                              parse_done1,

    output logic                              pp_meta_valid,
    output logic [RCI_NBITS-1:0]              pp_meta_rci,
    output logic                              trunc_err
);

    localparam int                   HI_NBITS = 3 + RCI_NBITS + BP_NBITS;
    localparam logic [IDX_NBITS-1:0] IDX_ONE  = 1;
    localparam logic [IDX_NBITS-1:0] IDX_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FREE,
        ST_FIFO_RST,
        ST_SKIP,
        ST_WRITE,
        ST_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic                   wptr_q, wptr_d;
    logic [1:0]             busy_q, busy_d;
    logic [IDX_NBITS-1:0]   cur_idx_q, cur_idx_d;
    logic [IDX_NBITS-1:0]   idx_q, idx_d;
    logic [RCI_NBITS-1:0]   rci_q, rci_d;
    logic [1:0]             wr_q, wr_d;
    logic [1:0]             fifo_rst_q, fifo_rst_d;
    logic [HI_NBITS-1:0]    wdata0_q, wdata0_d;
    logic [HI_NBITS-1:0]    wdata1_q, wdata1_d;
    logic                   meta_vld_q, meta_vld_d;
    logic [RCI_NBITS-1:0]   meta_rci_q, meta_rci_d;
    logic                   trunc_q, trunc_d;

    // Per-FIFO status gathered into vectors so the active one is picked by wptr.
    logic [1:0]             full_v, fullm1_v, done_v;
    logic                   cur_full, cur_fullm1, cur_wr, cur_done;
    logic                   skip_last, idx_last, accept, end_pkt, ready_raw;
    logic [BP_NBITS-1:0]    bp;
    logic [HI_NBITS-1:0]    hop_rec;
    logic                   unused_data_bits;

    assign full_v     = {hop_fifo_full1,   hop_fifo_full0};
    assign fullm1_v   = {hop_fifo_fullm11, hop_fifo_fullm10};
    assign done_v     = {parse_done1,      parse_done0};
    assign cur_full   = full_v[wptr_q];
    assign cur_fullm1 = fullm1_v[wptr_q];
    assign cur_wr     = wr_q[wptr_q];
    assign cur_done   = done_v[wptr_q];

    // Words before hop cur_idx-1 are not needed by the parser; hop cur_idx-1 is the
    // first one kept. With cur_idx==0 nothing is skipped.
    assign skip_last  = (cur_idx_q == '0) || (idx_q == (cur_idx_q - IDX_ONE));
    assign idx_last   = (idx_q == IDX_MAX);

    // Byte pointer of the hop: a packet still at its initial hop marks hop 0 with the
    // sentinel, everything else is its byte offset (wrapping at BP_NBITS).
    assign bp = ((cur_idx_q == '0) && (idx_q == '0)) ? INITIAL_HOP_PTR
              : BP_NBITS'(HDR_OFFSET) + BP_NBITS'({idx_q, 2'b00});

    assign hop_rec = {hop_in_data[31:29], hop_in_data[RCI_NBITS-1:0], bp};

    assign unused_data_bits = ^hop_in_data[28:RCI_NBITS];

    // In SKIP the ready is withheld on the final skip cycle so the first kept word
    // stays on the bus for WRITE. In WRITE, a write already in flight counts against
    // a one-from-full FIFO.
    always_comb begin
        ready_raw = 1'b0;
        case (state_q)
            ST_SKIP:  ready_raw = ~skip_last;
            ST_WRITE: ready_raw = ~cur_full & ~(cur_fullm1 & cur_wr);
            ST_DRAIN: ready_raw = 1'b1;
            default:  ready_raw = 1'b0;
        endcase
    end

    assign hop_in_ready = ready_raw & ~rst;
    assign accept       = hop_in_valid & hop_in_ready;
    assign end_pkt      = accept & hop_in_eop;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        cur_idx_d  = cur_idx_q;
        rci_d      = rci_q;
        idx_d      = idx_q;
        wr_d       = '0;
        fifo_rst_d = '0;
        wdata0_d   = wdata0_q;
        wdata1_d   = wdata1_q;
        meta_vld_d = 1'b0;
        meta_rci_d = meta_rci_q;
        trunc_d    = 1'b0;
        // Release first; a set in FIFO_RST below overrides a coincident release.
        busy_d     = busy_q & ~done_v;

        case (state_q)
            ST_IDLE: begin
                if (hop_in_valid && hop_in_sop) begin
                    cur_idx_d = hop_in_cur_idx;
                    rci_d     = hop_in_pkt_rci;
                    state_d   = ST_WAIT_FREE;
                end
            end

            // The clear and meta post are registered here so they appear during the
            // FIFO_RST cycle itself.
            ST_WAIT_FREE: begin
                if (!busy_q[wptr_q]) begin
                    fifo_rst_d[wptr_q] = 1'b1;
                    meta_vld_d         = 1'b1;
                    meta_rci_d         = rci_q;
                    state_d            = ST_FIFO_RST;
                end
            end

            ST_FIFO_RST: begin
                busy_d[wptr_q] = 1'b1;
                idx_d          = '0;
                state_d        = ST_SKIP;
            end

            // An eop here means the packet had fewer hops than cur_idx; the FIFO is
            // left empty and the packet is closed out normally.
            ST_SKIP: begin
                if (accept) begin
                    idx_d = idx_q + IDX_ONE;
                end
                if (end_pkt) begin
                    wptr_d  = ~wptr_q;
                    state_d = ST_IDLE;
                end else if (cur_done) begin
                    state_d = ST_DRAIN;
                end else if (skip_last) begin
                    state_d = ST_WRITE;
                end
            end

            // A word accepted in the cycle parse_done arrives is still written; it
            // lands in a FIFO that will be cleared before its next use.
            ST_WRITE: begin
                if (accept) begin
                    idx_d          = idx_q + IDX_ONE;
                    wr_d[wptr_q]   = 1'b1;
                    if (wptr_q) begin
                        wdata1_d = hop_rec;
                    end else begin
                        wdata0_d = hop_rec;
                    end
                end
                if (end_pkt) begin
                    wptr_d  = ~wptr_q;
                    state_d = ST_IDLE;
                end else if (accept && idx_last) begin
                    trunc_d = 1'b1;
                    state_d = ST_DRAIN;
                end else if (cur_done) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (end_pkt) begin
                    wptr_d  = ~wptr_q;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= 1'b0;
            busy_q     <= '0;
            cur_idx_q  <= '0;
            idx_q      <= '0;
            rci_q      <= '0;
            wr_q       <= '0;
            fifo_rst_q <= '0;
            wdata0_q   <= '0;
            wdata1_q   <= '0;
            meta_vld_q <= 1'b0;
            meta_rci_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            busy_q     <= busy_d;
            cur_idx_q  <= cur_idx_d;
            idx_q      <= idx_d;
            rci_q      <= rci_d;
            wr_q       <= wr_d;
            fifo_rst_q <= fifo_rst_d;
            wdata0_q   <= wdata0_d;
            wdata1_q   <= wdata1_d;
            meta_vld_q <= meta_vld_d;
            meta_rci_q <= meta_rci_d;
            trunc_q    <= trunc_d;
        end
    end

    // The parser must not release a FIFO in the very cycle it is being claimed.
    a_no_set_clear_clash: assert property (@(posedge clk) disable iff (rst)
        !((state_q == ST_FIFO_RST) && done_v[wptr_q]));

    assign hop_fifo_reset0 = fifo_rst_q[0];
    assign hop_fifo_reset1 = fifo_rst_q[1];
    assign hop_fifo_wr0    = wr_q[0];
    assign hop_fifo_wr1    = wr_q[1];
    assign hop_fifo_wdata0 = wdata0_q;
    assign hop_fifo_wdata1 = wdata1_q;
    assign pp_meta_valid   = meta_vld_q;
    assign pp_meta_rci     = meta_rci_q;
    assign trunc_err       = trunc_q;

endmodule

// File: doc/pp_hop_extract.md
Name: pp_hop_extract

Overview:
- Path Parser front end. Takes the hop-word stream of each packet's path header from the header buffer and converts each hop word into a hop_info record.
- Writes the records into one of the two ping-pong hop FIFOs inside the Path Parser state machine, and posts the packet's RCI to the parser's meta FIFO.
- Alternates FIFOs per packet. Honours FIFO backpressure. Drops hops the parser no longer needs. Releases a FIFO only after the parser signals parse_done for it.

Parameters:
- RCI_NBITS, 16, width of RCI field in hop word and hop_info.
- BP_NBITS, 12, width of byte-pointer field in hop_info.
- HDR_OFFSET, 24, byte offset of hop 0 within the packet.
- INITIAL_HOP_PTR, 12'hFFF, byte pointer value that marks an initial-hop packet.
- IDX_NBITS, 6, width of hop index; at most 64 hops per packet.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hop_in_valid  in  1  hop word valid
- hop_in_ready  out  1  hop word accepted when valid&ready
- hop_in_sop  in  1  first hop word of packet
- hop_in_eop  in  1  last hop word of packet
- hop_in_data  in  32  [31:29] hop type, [RCI_NBITS-1:0] RCI, rest ignored
- hop_in_cur_idx  in  IDX_NBITS  current hop index; valid with sop
- hop_in_pkt_rci  in  RCI_NBITS  packet RCI; valid with sop
- hop_fifo_reset0/1  out  1  one-cycle FIFO clear
- hop_fifo_wr0/1  out  1  FIFO write
- hop_fifo_wdata0/1  out  3+RCI_NBITS+BP_NBITS  {type, rci, byte_pointer}
- hop_fifo_full0/1, hop_fifo_fullm10/1  in  1  FIFO status
- parse_done0/1  in  1  parser finished with FIFO 0/1
- pp_meta_valid  out  1  meta FIFO write
- pp_meta_rci  out  RCI_NBITS  packet RCI
- trunc_err  out  1  one-cycle pulse when a packet exceeds 2^IDX_NBITS hops

Behaviour:
- Outputs and reset:
  - All FIFO and meta outputs are registered, giving one cycle from input acceptance to write.
  - Reset drives every output to 0 and sets wptr=0, busy0=busy1=0, state=IDLE.
  - A reset that arrives mid-packet abandons the packet. Upstream is also reset.
- busyk:
  - Set on the FIFO_RST cycle for FIFO k.
  - Cleared on parse_donek.
  - If set and clear coincide, set wins. This cannot legally occur and is asserted against in simulation.
- State machine. Transitions are evaluated each cycle.
  - IDLE: hop_in_ready=0. On hop_in_valid&sop, latch cur_idx and pkt_rci, then go to WAIT_FREE.
  - WAIT_FREE: hop_in_ready=0. When busy[wptr]==0, go to FIFO_RST.
  - FIFO_RST:
    - Pulse hop_fifo_reset[wptr] for one cycle and set busy[wptr].
    - Pulse pp_meta_valid with the latched RCI.
    - Set idx=0 and go to SKIP.
  - SKIP:
    - hop_in_ready=1. Accepted words with idx < cur_idx-1 are discarded, and idx increments.
    - When cur_idx==0, or when idx reaches cur_idx-1, go to WRITE without consuming a word.
    - If eop is accepted while in SKIP, that is an error: toggle wptr and go to IDLE. The parser will see an empty FIFO; upstream guarantees cur_idx is less than the hop count.
  - WRITE:
    - hop_in_ready = ~full[wptr] & ~(fullm1[wptr] & hop_fifo_wr[wptr]).
    - On accept, write {data[31:29], data[RCI], bp}.
    - bp = INITIAL_HOP_PTR when cur_idx==0 and idx==0; otherwise bp = HDR_OFFSET + 4*idx, truncated to BP_NBITS (wraps).
    - idx increments.
    - On accepted eop, toggle wptr and go to IDLE.
  - DRAIN: hop_in_ready=1. Discard words. On accepted eop, toggle wptr and go to IDLE.
- Parser completes early: parse_done[wptr] arrives during SKIP or WRITE → go to DRAIN from the next cycle. Any write registered in the same cycle still occurs; it lands in a FIFO that is cleared later.
- Truncation: if idx would wrap past 2^IDX_NBITS-1 in WRITE, pulse trunc_err and go to DRAIN.
- Overlap: the next packet's sop may be accepted in IDLE the cycle after eop. It then waits in WAIT_FREE for the other FIFO to be released.
- A parse_done for the non-active FIFO is handled independently in the same cycle.

Test Plan:
- Single packet, cur_idx=2, 5 hops, rci 0x0055 → FIFO0 reset pulse; meta 0x0055; 4 writes of hops 1..4 with bp 28,32,36,40; wptr becomes 1.
- cur_idx=0, 3 hops → first write bp=0xFFF, then 28, 32; hop_fifo_wr0 pulses 3 times.
- Hold hop_fifo_full0=1 for 10 cycles mid-packet → hop_in_ready=0, no write is lost or duplicated, order is preserved.
- Two back-to-back packets, parse_done0 delayed 20 cycles → packet 2 goes to FIFO1 immediately. Packet 3 waits in WAIT_FREE until the cycle after parse_done0, then hop_fifo_reset0 pulses.
- parse_done0 after the 2nd write of a 10-hop packet → remaining 8 words are consumed with ready=1 and no further hop_fifo_wr0.
- Packet with 65 hops, cur_idx=0 → 64 writes, trunc_err one pulse, last hop drained; assert rst mid-packet → all outputs 0 the next cycle.
